// File: rtl/memory_arbiter.sv
// Arbitrates the single rv32i word-memory port between instruction fetch and load/store.
// One transaction in flight; round-robin on collisions; every output is a register.
module memory_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_grant,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] fetch_data,
  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  output logic                  data_grant,
  output logic                  data_valid,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic                  mem_read_enable,
  output logic [ADDR_WIDTH-1:0] mem_read_address,
  input  logic [DATA_WIDTH-1:0] mem_read_value,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_write_address,
  output logic [DATA_WIDTH-1:0] mem_write_value
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                r_state,  w_state;
  logic [CNT_W-1:0]      r_cnt,    w_cnt;
  logic                  r_ptr_data, w_ptr_data;
  logic                  r_is_data,  w_is_data;
  logic                  r_is_store, w_is_store;
  logic                  w_pick_data;

  logic                  r_fetch_grant, w_fetch_grant;
  logic                  r_fetch_valid, w_fetch_valid;
  logic [DATA_WIDTH-1:0] r_fetch_data,  w_fetch_data;
  logic                  r_data_grant,  w_data_grant;
  logic                  r_data_valid,  w_data_valid;
  logic [DATA_WIDTH-1:0] r_data_rdata,  w_data_rdata;
  logic                  r_mem_ren,     w_mem_ren;
  logic [ADDR_WIDTH-1:0] r_mem_raddr,   w_mem_raddr;
  logic                  r_mem_wen,     w_mem_wen;
  logic [ADDR_WIDTH-1:0] r_mem_waddr,   w_mem_waddr;
  logic [DATA_WIDTH-1:0] r_mem_wval,    w_mem_wval;

  // Next-state and next-output logic; outputs are computed one cycle ahead and registered.
  always_comb begin
    w_state       = r_state;
    w_cnt         = r_cnt;
    w_ptr_data    = r_ptr_data;
    w_is_data     = r_is_data;
    w_is_store    = r_is_store;
    w_pick_data   = data_req && (!fetch_req || r_ptr_data);
    w_fetch_grant = 1'b0;
    w_fetch_valid = 1'b0;
    w_fetch_data  = r_fetch_data;
    w_data_grant  = 1'b0;
    w_data_valid  = 1'b0;
    w_data_rdata  = r_data_rdata;
    w_mem_ren     = 1'b0;
    w_mem_raddr   = r_mem_raddr;
    w_mem_wen     = 1'b0;
    w_mem_waddr   = r_mem_waddr;
    w_mem_wval    = r_mem_wval;

    case (r_state)
      S_IDLE: begin
        if (fetch_req || data_req) begin
          w_state    = S_ISSUE;
          w_cnt      = '0;
          w_is_data  = w_pick_data;
          w_is_store = w_pick_data && data_we;
          if (w_pick_data) begin
            w_data_grant = 1'b1;
            w_mem_raddr  = data_addr;
            if (data_we) begin
              w_mem_wen   = 1'b1;
              w_mem_waddr = data_addr;
              w_mem_wval  = data_wdata;
            end else begin
              w_mem_ren = 1'b1;
            end
          end else begin
            w_fetch_grant = 1'b1;
            w_mem_ren     = 1'b1;
            w_mem_raddr   = fetch_addr;
          end
        end
      end
      S_ISSUE: begin
        // Stores commit on the strobe edge, so they skip the read wait.
        if (r_is_store) begin
          w_state      = S_RESP;
          w_data_valid = 1'b1;
        end else begin
          w_state = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == LAST_CNT) begin
          w_state = S_RESP;
          w_cnt   = '0;
          if (r_is_data) begin
            w_data_valid = 1'b1;
            w_data_rdata = mem_read_value;
          end else begin
            w_fetch_valid = 1'b1;
            w_fetch_data  = mem_read_value;
          end
        end else begin
          w_cnt = CNT_W'(r_cnt + 1'b1);
        end
      end
      S_RESP: begin
        w_state    = S_IDLE;
        w_ptr_data = !r_is_data;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_ptr_data    <= 1'b0;
      r_is_data     <= 1'b0;
      r_is_store    <= 1'b0;
      r_fetch_grant <= 1'b0;
      r_fetch_valid <= 1'b0;
      r_fetch_data  <= '0;
      r_data_grant  <= 1'b0;
      r_data_valid  <= 1'b0;
      r_data_rdata  <= '0;
      r_mem_ren     <= 1'b0;
      r_mem_raddr   <= '0;
      r_mem_wen     <= 1'b0;
      r_mem_waddr   <= '0;
      r_mem_wval    <= '0;
    end else begin
      r_state       <= w_state;
      r_cnt         <= w_cnt;
      r_ptr_data    <= w_ptr_data;
      r_is_data     <= w_is_data;
      r_is_store    <= w_is_store;
      r_fetch_grant <= w_fetch_grant;
      r_fetch_valid <= w_fetch_valid;
      r_fetch_data  <= w_fetch_data;
      r_data_grant  <= w_data_grant;
      r_data_valid  <= w_data_valid;
      r_data_rdata  <= w_data_rdata;
      r_mem_ren     <= w_mem_ren;
      r_mem_raddr   <= w_mem_raddr;
      r_mem_wen     <= w_mem_wen;
      r_mem_waddr   <= w_mem_waddr;
      r_mem_wval    <= w_mem_wval;
    end
  end

  assign fetch_grant       = r_fetch_grant;
  assign fetch_valid       = r_fetch_valid;
  assign fetch_data        = r_fetch_data;
  assign data_grant        = r_data_grant;
  assign data_valid        = r_data_valid;
  assign data_rdata        = r_data_rdata;
  assign mem_read_enable   = r_mem_ren;
  assign mem_read_address  = r_mem_raddr;
  assign mem_write_enable  = r_mem_wen;
  assign mem_write_address = r_mem_waddr;
  assign mem_write_value   = r_mem_wval;

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: transaction-level reference model feeds an expected-event
// queue; a negedge monitor pops and compares each grant/valid pulse. A second instance uses latency 3.
module tb_memory_arbiter;

  localparam int unsigned L1 = 1;

  typedef struct {
    int          cyc;
    int          kind;   // 0 fetch grant, 1 data grant, 2 fetch valid, 3 data valid
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] data;
  } ev_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        do_init;
  logic        fetch_req, data_req, data_we;
  logic [31:0] fetch_addr, data_addr, data_wdata;
  logic        fetch_grant, fetch_valid, data_grant, data_valid;
  logic [31:0] fetch_data, data_rdata;
  logic        mem_read_enable, mem_write_enable;
  logic [31:0] mem_read_address, mem_write_address, mem_write_value, mem_read_value;

  logic        d2_req;
  logic [31:0] d2_addr;
  logic        f2_grant, f2_valid, d2_grant, d2_valid, m2_ren, m2_wen;
  logic [31:0] f2_data, d2_rdata, m2_raddr, m2_waddr, m2_wval, m2_rval;

  int          cyc = 0;
  int          nchk = 0;
  int          npass = 0;
  int          free_edge = 0;
  logic        ptr_data = 1'b0;
  logic [31:0] ref_mem [64];
  logic [31:0] mem [64];
  logic [31:0] p2 [3];
  ev_t         sbq [$];

  always #5 clock = ~clock;

  memory_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(L1)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_grant(fetch_grant),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_grant(data_grant), .data_valid(data_valid), .data_rdata(data_rdata),
    .mem_read_enable(mem_read_enable), .mem_read_address(mem_read_address),
    .mem_read_value(mem_read_value), .mem_write_enable(mem_write_enable),
    .mem_write_address(mem_write_address), .mem_write_value(mem_write_value)
  );

  memory_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(3)) u_dut3 (
    .clock(clock), .reset_n(reset_n),
    .fetch_req(1'b0), .fetch_addr(32'h0), .fetch_grant(f2_grant),
    .fetch_valid(f2_valid), .fetch_data(f2_data),
    .data_req(d2_req), .data_we(1'b0), .data_addr(d2_addr), .data_wdata(32'h0),
    .data_grant(d2_grant), .data_valid(d2_valid), .data_rdata(d2_rdata),
    .mem_read_enable(m2_ren), .mem_read_address(m2_raddr),
    .mem_read_value(m2_rval), .mem_write_enable(m2_wen),
    .mem_write_address(m2_waddr), .mem_write_value(m2_wval)
  );

  function automatic logic [31:0] init_val(input int i);
    return (i == 4) ? 32'hDEADBEEF : 32'hC0DE_0000 + 32'(i) * 32'h11;
  endfunction

  function automatic logic [31:0] rom_f(input logic [5:0] w);
    return 32'hA5C3_0000 + 32'(w);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic chk_zero(input string nm);
    logic any;
    any = |{fetch_grant, fetch_valid, fetch_data, data_grant, data_valid, data_rdata,
            mem_read_enable, mem_read_address, mem_write_enable, mem_write_address, mem_write_value};
    chk(nm, 32'(any), 32'h0);
  endtask

  // Memory behind the latency-1 instance: write on strobe edge, read data one cycle later.
  always @(posedge clock) begin
    if (do_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
    end else if (mem_write_enable) begin
      mem[mem_write_address[7:2]] <= mem_write_value;
    end
    mem_read_value <= mem_read_enable ? mem[mem_read_address[7:2]] : 32'h0;
  end

  // Latency-3 read-only memory; the value exists only on the exact return cycle.
  always @(posedge clock) begin
    p2[0] <= m2_ren ? rom_f(m2_raddr[7:2]) : 32'h0;
    p2[1] <= p2[0];
    p2[2] <= p2[1];
  end
  assign m2_rval = p2[2];

  // Transaction-level reference: decides the winner at each sampling edge and schedules events.
  always @(posedge clock) begin : model
    ev_t  e;
    logic pick_d;
    cyc = cyc + 1;
    if (do_init) for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    if (!reset_n) begin
      sbq.delete();
      ptr_data  = 1'b0;
      free_edge = cyc + 1;
    end else if (cyc >= free_edge && (fetch_req || data_req)) begin
      pick_d  = data_req && (!fetch_req || ptr_data);
      e.cyc   = cyc;
      e.kind  = pick_d ? 1 : 0;
      e.addr  = pick_d ? data_addr : fetch_addr;
      e.we    = pick_d && data_we;
      e.wdata = data_wdata;
      e.data  = 32'h0;
      sbq.push_back(e);
      if (e.we) begin
        ref_mem[e.addr[7:2]] = data_wdata;
        e.cyc     = cyc + 1;
        free_edge = cyc + 3;
      end else begin
        e.data    = ref_mem[e.addr[7:2]];
        e.cyc     = cyc + 1 + int'(L1);
        free_edge = cyc + 3 + int'(L1);
      end
      e.kind = pick_d ? 3 : 2;
      sbq.push_back(e);
      ptr_data = !pick_d;
    end
  end

  always @(negedge clock) begin : monitor
    ev_t e;
    int  np;
    int  akind;
    while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
      nchk++;
      $display("FAIL missed_event: kind %0d due at cycle %0d never seen (now %0d)", sbq[0].kind, sbq[0].cyc, cyc);
      void'(sbq.pop_front());
    end
    chk("strobe_onehot", 32'(mem_read_enable & mem_write_enable), 32'h0);
    chk("strobe_vs_grant", 32'(mem_read_enable | mem_write_enable), 32'(fetch_grant | data_grant));
    np = int'(fetch_grant) + int'(data_grant) + int'(fetch_valid) + int'(data_valid);
    if (np > 1) begin
      nchk++;
      $display("FAIL multi_pulse: %0d pulses in one cycle (cycle %0d)", np, cyc);
    end else if (np == 1) begin
      akind = fetch_grant ? 0 : data_grant ? 1 : fetch_valid ? 2 : 3;
      if (sbq.size() == 0) begin
        nchk++;
        $display("FAIL unexpected_pulse: kind %0d with nothing expected (cycle %0d)", akind, cyc);
      end else begin
        e = sbq.pop_front();
        chk("event_kind", 32'(akind), 32'(e.kind));
        chk("event_cycle", 32'(cyc), 32'(e.cyc));
        if (e.kind < 2) begin
          chk("rd_addr", mem_read_address, e.addr);
          if (e.we) begin
            chk("wr_en", 32'(mem_write_enable), 32'h1);
            chk("wr_addr", mem_write_address, e.addr);
            chk("wr_value", mem_write_value, e.wdata);
          end else begin
            chk("rd_en", 32'(mem_read_enable), 32'h1);
          end
        end else if (e.kind == 2) begin
          chk("fetch_data", fetch_data, e.data);
        end else if (!e.we) begin
          chk("data_rdata", data_rdata, e.data);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_fetch(input logic [31:0] a);
    fetch_req  = 1'b1;
    fetch_addr = a;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (fetch_grant) begin
        fetch_req = 1'b0;
        return;
      end
    end
    fetch_req = 1'b0;
    nchk++;
    $display("FAIL fetch_grant_timeout: no grant for addr %0h", a);
  endtask

  task automatic do_data(input logic we, input logic [31:0] a, input logic [31:0] wd);
    data_req   = 1'b1;
    data_we    = we;
    data_addr  = a;
    data_wdata = wd;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (data_grant) begin
        data_req = 1'b0;
        return;
      end
    end
    data_req = 1'b0;
    nchk++;
    $display("FAIL data_grant_timeout: no grant for addr %0h", a);
  endtask

  task automatic drive_rand();
    if (fetch_req) begin
      if (fetch_grant || $urandom_range(0, 19) == 0) fetch_req = 1'b0;
    end else if ($urandom_range(0, 2) == 0) begin
      fetch_req  = 1'b1;
      fetch_addr = 32'($urandom_range(0, 255));
    end
    if (data_req) begin
      if (data_grant || $urandom_range(0, 19) == 0) data_req = 1'b0;
    end else if ($urandom_range(0, 2) == 0) begin
      data_req   = 1'b1;
      data_we    = 1'($urandom_range(0, 1));
      data_addr  = 32'($urandom_range(0, 255));
      data_wdata = $urandom;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int g [4];
    int n;
    int dg;
    int t0;
    logic first_done;
    logic seen;

    reset_n = 1'b0; do_init = 1'b1;
    fetch_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
    fetch_addr = 32'h0; data_addr = 32'h0; data_wdata = 32'h0;
    d2_req = 1'b0; d2_addr = 32'h0;
    idle(3);
    chk_zero("reset_outputs");
    do_init = 1'b0;
    reset_n = 1'b1;
    idle(1);

    // Single fetch of word 4.
    do_fetch(32'h10);
    idle(4);
    chk("t1_fetch_data", fetch_data, 32'hDEADBEEF);

    // Store then load back.
    do_data(1'b1, 32'h20, 32'h12345678);
    idle(3);
    do_data(1'b0, 32'h20, 32'h0);
    idle(4);
    chk("t2_load_back", data_rdata, 32'h12345678);

    // Both requesters held high: grants alternate starting with fetch.
    for (int i = 0; i < 4; i++) g[i] = 9;
    n = 0;
    fetch_addr = 32'h30; data_addr = 32'h34; data_we = 1'b0;
    fetch_req = 1'b1; data_req = 1'b1;
    for (int k = 0; k < 60 && n < 4; k++) begin
      @(negedge clock);
      if (fetch_grant) begin g[n] = 0; n++; end
      else if (data_grant) begin g[n] = 1; n++; end
    end
    fetch_req = 1'b0; data_req = 1'b0;
    chk("t3_grant_count", 32'(n), 32'd4);
    for (int i = 0; i < 4; i++) chk("t3_grant_order", 32'(g[i]), 32'(i % 2));
    idle(6);

    // One-cycle data_req pulse while a fetch waits on memory is never sampled.
    do_fetch(32'h40);
    @(negedge clock);
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h44;
    @(negedge clock);
    data_req = 1'b0;
    dg = 0;
    repeat (8) begin
      @(negedge clock);
      if (data_grant) dg++;
    end
    chk("t6_no_data_grant", 32'(dg), 32'h0);

    // Reset during the wait of a fetch, then both request: fetch must win first.
    do_fetch(32'h10);
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    chk_zero("t4_outputs_zero");
    chk("t4_no_fetch_valid", 32'(fetch_valid), 32'h0);
    reset_n = 1'b1;
    fetch_addr = 32'h18; data_addr = 32'h1C; data_we = 1'b0;
    fetch_req = 1'b1; data_req = 1'b1;
    first_done = 1'b0;
    for (int k = 0; k < 40 && (fetch_req || data_req); k++) begin
      @(negedge clock);
      if ((fetch_grant || data_grant) && !first_done) begin
        chk("t4_first_grant_fetch", 32'(fetch_grant), 32'h1);
        first_done = 1'b1;
      end
      if (fetch_grant) fetch_req = 1'b0;
      if (data_grant) data_req = 1'b0;
    end
    if (!first_done) begin
      nchk++;
      $display("FAIL t4_grant_timeout: no grant after reset");
    end
    fetch_req = 1'b0; data_req = 1'b0;
    idle(6);

    // Randomized traffic against the reference model.
    repeat (800) begin
      @(negedge clock);
      drive_rand();
    end
    fetch_req = 1'b0; data_req = 1'b0;
    idle(12);
    chk("scoreboard_drained", 32'(sbq.size()), 32'h0);

    // Latency-3 load of word 1: valid exactly four edges after the sampling edge.
    d2_req = 1'b1; d2_addr = 32'h4;
    t0 = cyc + 1;
    seen = 1'b0;
    for (int k = 0; k < 15 && !seen; k++) begin
      @(negedge clock);
      if (d2_grant) begin
        d2_req = 1'b0;
        chk("t5_grant_cycle", 32'(cyc), 32'(t0));
      end
      if (d2_valid) begin
        chk("t5_valid_cycle", 32'(cyc), 32'(t0 + 4));
        chk("t5_rdata", d2_rdata, rom_f(6'd1));
        seen = 1'b1;
      end
    end
    d2_req = 1'b0;
    if (!seen) begin
      nchk++;
      $display("FAIL t5_valid_timeout: no data_valid from latency-3 instance");
    end
    idle(2);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
